fetch_unit: RTL

Instruction fetch stage directly upstream of the control-unit decoder.
- Holds the PC and issues word reads to instruction memory.
- Buffers returned words in a small FIFO.
- Presents one instruction per valid/ready handshake, with pre-split fields (cond, op, funct, rd) that the decoder consumes.
- Handles branch redirects from execute by flushing buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: decoder field positions,
// fetch FSM state encoding and the instruction-buffer entry layout.
package fetch_pkg;

    localparam int unsigned COND_HI  = 31;
    localparam int unsigned COND_LO  = 28;
    localparam int unsigned OP_HI    = 27;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned FUNCT_HI = 25;
    localparam int unsigned FUNCT_LO = 20;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 12;

    // Buffer entries carry a full 32-bit PC; narrower ADDR_W is zero-extended.
    localparam int unsigned ENTRY_PC_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [31:0]           word;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage: synchronous FIFO with occupancy count
// and a flush that overrides any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output fifo_entry_t      head
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, buffered delivery
// to the decoder with redirect flush. Optional perf counters under FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc8,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned       CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned       OCC_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  DEPTH_O = OCC_W'(FIFO_DEPTH);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              drop, drop_nx;
    logic              push;
    logic              fire;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  count;
    fifo_entry_t       push_data;
    fifo_entry_t       head;

    assign instr_valid = (count != '0);
    assign fire        = instr_valid && instr_ready;

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        push     = 1'b0;
        drop_nx  = drop;
        occ      = '0;
        case (state)
            IDLE: state_nx = ISSUE;
            ISSUE: begin
                if (!redirect_valid && count < DEPTH_C) begin
                    imem_req = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = !drop && !redirect_valid;
                    drop_nx = 1'b0;
                    // Re-issue in the response cycle using post-push/pop occupancy.
                    occ = {1'b0, count} + OCC_W'(push) - OCC_W'(fire);
                    if (!redirect_valid && occ < DEPTH_O) imem_req = 1'b1;
                    else                                  state_nx = ISSUE;
                end else if (redirect_valid) begin
                    drop_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        imem_addr = imem_req ? fetch_pc : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else begin
            state <= state_nx;
            drop  <= drop_nx;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ADDR_W'(3);
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
                req_pc   <= fetch_pc;
            end
        end
    end

    assign push_data.pc   = ENTRY_PC_W'(req_pc);
    assign push_data.word = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (fire),
        .count     (count),
        .head      (head)
    );

    assign instr     = instr_valid ? head.word : '0;
    assign instr_pc  = instr_valid ? head.pc[ADDR_W-1:0] : '0;
    assign instr_pc8 = instr_valid ? head.pc[ADDR_W-1:0] + ADDR_W'(8) : '0;
    assign cond      = instr[COND_HI:COND_LO];
    assign op        = instr[OP_HI:OP_LO];
    assign funct     = instr[FUNCT_HI:FUNCT_LO];
    assign rd        = instr[RD_HI:RD_LO];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fire)                        perf_fetched <= perf_fetched + 32'd1;
            if (instr_valid && !instr_ready) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
